// File: rtl/input_csr.sv
// Memory-mapped receive FIFO: bytes arrive on rx_stb_i, the CPU polls and pops
// them through a single CSR that also carries status, overrun clear and flush.
module input_csr #(
  parameter logic [11:0] CSR_ADDR = 12'h0FE,
  parameter int          DEPTH    = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [11:0] cadr_i,
  output logic        cvalid_o,
  output logic [63:0] cdat_o,
  input  logic [63:0] cdat_i,
  input  logic        coe_i,
  input  logic        cwe_i,
  input  logic [7:0]  rx_dat_i,
  input  logic        rx_stb_i,
  output logic        rx_avail_o,
  output logic        rx_full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;

  logic valid, full, pop, push, flush, ov_clr, ov_set;
  logic unused_cdat_bits;

  assign unused_cdat_bits = ^{cdat_i[63:11], cdat_i[8:0]};

  assign cvalid_o   = (cadr_i == CSR_ADDR);
  assign valid      = (count_q != '0);
  assign full       = (count_q == CW'(DEPTH));
  assign rx_avail_o = valid;
  assign rx_full_o  = full;

  assign pop    = cvalid_o & coe_i & valid;
  assign flush  = cvalid_o & cwe_i & cdat_i[10];
  assign ov_clr = cvalid_o & cwe_i & cdat_i[9];
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push   = rx_stb_i & (~full | pop) & ~flush;
  assign ov_set = rx_stb_i & full & ~pop & ~flush;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = ov_set | (overrun_q & ~ov_clr);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is not reset; COUNT alone decides which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= rx_dat_i;
  end

  always_comb begin
    cdat_o = '0;
    if (cvalid_o) begin
      cdat_o[7:0]      = valid ? mem_q[rd_ptr_q] : 8'h00;
      cdat_o[8]        = valid;
      cdat_o[9]        = overrun_q;
      cdat_o[10 +: CW] = count_q;
    end
  end

endmodule

// File: tb/tb_input_csr.sv
// Bench for input_csr: directed scenarios with literal expectations, then random
// traffic, all outputs compared every cycle against a queue-based model.
module tb_input_csr;

  localparam logic [11:0] ADDR = 12'h0FE;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] cadr;
  logic        cvalid;
  logic [63:0] cdat_o;
  logic [63:0] wdat;
  logic        coe, cwe;
  logic [7:0]  rxd;
  logic        stb;
  logic        avail, full;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  bit         m_ov = 1'b0;

  input_csr #(.CSR_ADDR(12'h0FE), .DEPTH(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cadr_i(cadr), .cvalid_o(cvalid),
    .cdat_o(cdat_o), .cdat_i(wdat), .coe_i(coe), .cwe_i(cwe),
    .rx_dat_i(rxd), .rx_stb_i(stb), .rx_avail_o(avail), .rx_full_o(full)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: byte queue plus sticky overrun flag
  function automatic logic [63:0] exp_cdat();
    logic [63:0] r;
    int n;
    r = '0;
    n = exp_q.size();
    if (cadr == ADDR) begin
      r[7:0]   = (n != 0) ? exp_q[0] : 8'h00;
      r[8]     = (n != 0);
      r[9]     = m_ov;
      r[13:10] = 4'(n);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    bit sel, do_pop, do_flush, do_clr, was_full, do_set;
    if (rst_n) begin
      sel      = (cadr == ADDR);
      do_pop   = sel && coe && (exp_q.size() > 0);
      do_flush = sel && cwe && wdat[10];
      do_clr   = sel && cwe && wdat[9];
      was_full = (exp_q.size() == 8);
      do_set   = stb && was_full && !do_pop && !do_flush;
      if (do_pop) void'(exp_q.pop_front());
      if (stb && (!was_full || do_pop)) exp_q.push_back(rxd);
      if (do_flush) exp_q.delete();
      if (do_set) m_ov = 1'b1;
      else if (do_clr) m_ov = 1'b0;
    end
  end

  always @(negedge rst_n) begin
    exp_q.delete();
    m_ov = 1'b0;
  end

  // compare process
  always @(negedge clk) begin
    check("cvalid", {63'b0, cvalid}, {63'b0, cadr == ADDR});
    check("cdat", cdat_o, exp_cdat());
    check("rx_avail", {63'b0, avail}, {63'b0, exp_q.size() != 0});
    check("rx_full", {63'b0, full}, {63'b0, exp_q.size() == 8});
  end

  // driver tasks
  task automatic idle();
    cadr = 12'h000; coe = 1'b0; cwe = 1'b0; wdat = '0; stb = 1'b0; rxd = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    idle();
    stb = 1'b1;
    rxd = b;
    tick();
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (3) tick();
    cadr = ADDR;
    #1;
    check("reset_cdat", cdat_o, 64'h0);
    check("reset_avail", {63'b0, avail}, 64'h0);
    check("reset_full", {63'b0, full}, 64'h0);
    rst_n = 1'b1;
    idle();
    tick();

    // two bytes, popped back to back
    push_byte(8'h41);
    push_byte(8'h42);
    cadr = ADDR; coe = 1'b1;
    #1; check("pop_first", cdat_o, 64'h941);
    tick();
    #1; check("pop_second", cdat_o, 64'h542);
    tick();
    #1; check("pop_empty", cdat_o, 64'h0);
    check("avail_falls", {63'b0, avail}, 64'h0);
    idle();

    // nine pushes, no reads: overrun, ordering preserved
    for (int i = 0; i < 9; i++) push_byte(8'(i));
    cadr = ADDR;
    #1; check("full_status", cdat_o, 64'h2300);
    check("full_flag", {63'b0, full}, 64'h1);
    coe = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1; check("fifo_order", {56'b0, cdat_o[7:0]}, 64'(i));
      tick();
    end
    #1; check("overrun_kept", cdat_o, 64'h200);
    idle();
    cadr = ADDR; cwe = 1'b1; wdat = 64'h200;
    tick();
    idle();

    // push while full with a simultaneous pop
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
    cadr = ADDR; coe = 1'b1; stb = 1'b1; rxd = 8'hAA;
    tick();
    idle();
    cadr = ADDR;
    #1; check("full_push_pop", cdat_o, 64'h2111);
    coe = 1'b1;
    repeat (7) tick();
    #1; check("new_byte_last", {56'b0, cdat_o[7:0]}, 64'hAA);
    tick();
    idle();

    // overrun set beats clear in the same cycle
    for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i));
    cadr = ADDR; stb = 1'b1; rxd = 8'h55; cwe = 1'b1; wdat = 64'h200;
    tick();
    idle();
    cadr = ADDR;
    #1; check("set_wins", {63'b0, cdat_o[9]}, 64'h1);
    cwe = 1'b1; wdat = 64'h200;
    tick();
    idle();
    cadr = ADDR;
    #1; check("clear_ovr", cdat_o, 64'h2120);

    // flush beats a same-cycle push
    cwe = 1'b1; wdat = 64'h400;
    tick();
    idle();
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    cadr = ADDR; cwe = 1'b1; wdat = 64'h400; stb = 1'b1; rxd = 8'h77;
    tick();
    idle();
    cadr = ADDR;
    #1; check("flush_cdat", cdat_o, 64'h0);
    check("flush_avail", {63'b0, avail}, 64'h0);
    push_byte(8'h99);
    cadr = 12'h0FF;
    #1; check("other_addr_cvalid", {63'b0, cvalid}, 64'h0);
    check("other_addr_cdat", cdat_o, 64'h0);
    idle();

    // coe_i low does not pop; async reset discards contents
    for (int i = 0; i < 4; i++) push_byte(8'h60 + 8'(i));
    cadr = ADDR;
    #1; check("peek", cdat_o, 64'h1599);
    tick();
    #1; check("peek_again", cdat_o, 64'h1599);
    rst_n = 1'b0;
    #1; check("async_avail", {63'b0, avail}, 64'h0);
    check("async_cdat", cdat_o, 64'h0);
    tick();
    rst_n = 1'b1;
    idle();
    tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      if ($urandom_range(0, 199) == 0) begin
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      r = $urandom_range(0, 9);
      cadr = (r < 6) ? ADDR : (r < 8) ? 12'h0FF : 12'($urandom_range(0, 4095));
      coe = 1'($urandom_range(0, 1));
      cwe = ($urandom_range(0, 7) == 0);
      wdat = {$urandom(), $urandom()};
      wdat[10] = ($urandom_range(0, 15) == 0);
      wdat[9] = ($urandom_range(0, 3) == 0);
      stb = ($urandom_range(0, 2) != 0);
      rxd = 8'($urandom_range(0, 255));
      tick();
    end
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
